chip_cap_ctrl: RTL and testbench
================================

Name: chip_cap_ctrl

Overview:
Capture sequencer for the chip path selector. It arms the path, gates its buffer-ready input, and fixes the frame length for each capture. It counts accepted samples into the frame buffer, latches which sensor path fired, and holds the frame until the host has read it out. Optional holdoff and auto re-arm support continuous acquisition.

Parameters:
LEN_W, 20, width of frame length and sample counters
DEF_LEN, 4000, frame length used when cfg_frame_len == 0
HO_W, 16, holdoff counter width
TO_W, 24, arm-timeout counter width

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous reset, active-high
cmd_arm  in  1  one-cycle pulse; start a capture
cmd_abort  in  1  one-cycle pulse; return to IDLE
cfg_cont  in  1  1 = re-arm automatically after holdoff
cfg_frame_len  in  LEN_W  samples per frame; 0 selects DEF_LEN
cfg_holdoff  in  HO_W  idle cycles after readout before re-arm
cfg_timeout  in  TO_W  max cycles spent in ARMED; 0 disables the timeout
d1_vld  in  1  valid strobe from the path selector
sel_path  in  7  path index from the path selector
buf_afull  in  1  frame buffer almost full
rd_done  in  1  one-cycle pulse; host finished reading the frame
buf_rdy  out  1  ready to the path selector
cfg_len  out  LEN_W  frame length to the path selector
buf_wr  out  1  frame buffer write enable
frm_path  out  7  path latched at first accepted sample
frm_cnt  out  LEN_W  samples accepted in the current frame
frm_done  out  1  level; frame complete and awaiting readout
irq  out  1  one-cycle pulse on frame complete or timeout
tmo  out  1  sticky; last arm timed out
ovf  out  1  sticky; sample dropped while not ready
frm_num  out  16  completed-frame counter, wraps
st  out  3  current state, for debug and status

Behaviour:
- Reset values: state IDLE; cfg_len = DEF_LEN; all other outputs 0.
- States: IDLE=0, ARMED=1, CAPT=2, DONE=3, HOLD=4.
- IDLE:
  - On cmd_arm: latch cfg_len (cfg_frame_len, or DEF_LEN if it is 0).
  - Clear frm_cnt, frm_path, tmo and ovf.
  - Go to ARMED.
- buf_rdy (combinational) = (st == ARMED or st == CAPT) and not buf_afull.
- buf_wr (combinational) = d1_vld and buf_rdy.
- ARMED:
  - The timeout counter increments every cycle.
  - First buf_wr: latch sel_path into frm_path, set frm_cnt = 1, go to CAPT.
  - Timeout: if cfg_timeout != 0 and the counter reaches cfg_timeout - 1 with no buf_wr, set tmo, pulse irq, go to IDLE.
- CAPT:
  - Each buf_wr increments frm_cnt.
  - The buf_wr that makes frm_cnt == cfg_len goes to DONE: frm_done = 1, irq pulses one cycle, frm_num increments.
  - If cfg_len == 1, ARMED goes directly to DONE on the first write.
- ovf is set on d1_vld and not buf_rdy while in CAPT. The path selector does not decrement on that sample, so the frame is still completed in full; the sample itself is lost.
- DONE: buf_rdy = 0. On rd_done: clear frm_done, load the holdoff counter, go to HOLD.
- HOLD:
  - Count cfg_holdoff cycles.
  - At expiry: go to ARMED (clear frm_cnt) if cfg_cont, else IDLE.
  - cfg_holdoff == 0 leaves HOLD after one cycle.
- cfg_len is stable from arm until the next arm. Changes to cfg_frame_len mid-frame have no effect.
- Priority:
  - cmd_abort beats every other event in the same cycle: go to IDLE, clear frm_done, no irq, frm_num unchanged.
  - An abort coinciding with the final write aborts the frame.
  - cmd_arm outside IDLE is ignored.
  - rd_done outside DONE is ignored.
- Counter wrap:
  - frm_num wraps 0xFFFF -> 0.
  - frm_cnt never exceeds cfg_len.
  - The timeout counter saturates.
- Asserting rst mid-operation returns to the reset values immediately. It does not wait for a clock edge.

Decomposition:
- Shared package chip_pkg holds:
  - state encodings IDLE..HOLD
  - DEF_LEN = 4000
  - the widths LEN_W, HO_W, TO_W
- One natural sub-module: chip_dncnt, a loadable down-counter with a zero flag. Instantiate it twice, once for holdoff and once for timeout.
- The FSM and the frame counters stay in chip_cap_ctrl.

Test Plan:
1. cfg_frame_len=0, arm, then 4000 d1_vld with buf_afull=0 -> cfg_len=4000, buf_wr count 4000, frm_done=1, irq pulses once, frm_num=1, st=DONE.
2. Arm with cfg_frame_len=8, sel_path=3 at the first write, 3 cycles of buf_afull mid-frame with d1_vld -> ovf=1, frm_path=3, frame still completes at 8 accepted writes.
3. cfg_timeout=100, arm, no d1_vld -> after 100 cycles tmo=1, irq pulses, st=IDLE, buf_rdy=0.
4. cfg_cont=1, cfg_holdoff=5, len=4; complete a frame, pulse rd_done -> buf_rdy stays 0 for 5 cycles, then st=ARMED; a second frame gives frm_num=2.
5. len=4, cmd_abort on the same cycle as the 4th write -> st=IDLE, frm_done=0, no irq, frm_num unchanged.
6. Assert rst during CAPT with frm_cnt=2 -> all outputs at reset values asynchronously; cmd_arm before the first capture proceeds normally.

Source files
------------

// File: rtl/chip_pkg.sv
// Shared definitions for the capture sequencer slice.
// Holds widths, default frame length and state encodings.
package chip_pkg;

    localparam int LEN_W   = 20;
    localparam int HO_W    = 16;
    localparam int TO_W    = 24;
    localparam int DEF_LEN = 4000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_CAPT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Frame length actually used: zero selects the default.
    function automatic logic [LEN_W-1:0] eff_len(
        input logic [LEN_W-1:0] len
    );
        return (len == '0) ? LEN_W'(DEF_LEN) : len;
    endfunction

endpackage

// File: rtl/chip_cap_ctrl_if.sv
// Path selector / frame buffer handshake bundle.
// slave: capture controller; master: selector + buffer side.
interface chip_cap_ctrl_if;
    import chip_pkg::*;

    logic             d1_vld;
    logic [6:0]       sel_path;
    logic             buf_afull;
    logic             buf_rdy;
    logic [LEN_W-1:0] cfg_len;
    logic             buf_wr;

    modport slave (
        input  d1_vld, sel_path, buf_afull,
        output buf_rdy, cfg_len, buf_wr
    );

    modport master (
        output d1_vld, sel_path, buf_afull,
        input  buf_rdy, cfg_len, buf_wr
    );

endinterface

// File: rtl/chip_dncnt.sv
// Loadable down-counter that holds at zero, with a zero flag.
// Ports: clk_sys, rst, load/load_val, en (decrement), zero.
module chip_dncnt #(
    parameter int W = 16
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/chip_cap_ctrl.sv
// Capture sequencer: arms the path, counts frame samples, holds for readout.
// Ports: clk_sys/rst, cmd_*, cfg_*, rd_done, ps (selector bundle), status.
module chip_cap_ctrl
    import chip_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             cmd_arm,
    input  logic             cmd_abort,
    input  logic             cfg_cont,
    input  logic [LEN_W-1:0] cfg_frame_len,
    input  logic [HO_W-1:0]  cfg_holdoff,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             rd_done,
    chip_cap_ctrl_if.slave   ps,
    output logic [6:0]       frm_path,
    output logic [LEN_W-1:0] frm_cnt,
    output logic             frm_done,
    output logic             irq,
    output logic             tmo,
    output logic             ovf,
    output logic [15:0]      frm_num,
    output logic [2:0]       st
);

    state_t           state;
    logic [LEN_W-1:0] cfg_len_q;
    logic             rdy;
    logic             wr;
    logic [LEN_W-1:0] cnt_nxt;
    logic             last;
    logic             rearm;
    logic             to_ld;
    logic [TO_W-1:0]  to_val;
    logic             to_zero;
    logic             tmo_hit;
    logic             ho_ld;
    logic [HO_W-1:0]  ho_val;
    logic             ho_zero;

    assign rdy = ((state == ST_ARMED) || (state == ST_CAPT))
               && !ps.buf_afull;
    assign wr  = ps.d1_vld && rdy;

    assign ps.buf_rdy = rdy;
    assign ps.buf_wr  = wr;
    assign ps.cfg_len = cfg_len_q;
    assign st         = state;

    // frm_cnt is 0 in ARMED, so one compare covers len == 1 too.
    assign cnt_nxt = frm_cnt + LEN_W'(1);
    assign last    = (cnt_nxt == cfg_len_q);

    assign rearm = (state == ST_HOLD) && ho_zero && cfg_cont;

    // Timeout counter reloads on every entry to ARMED and holds
    // at zero, which gives the saturating behaviour.
    assign to_ld  = ((state == ST_IDLE) && cmd_arm) || rearm;
    assign to_val = (cfg_timeout == '0) ? '0
                  : cfg_timeout - TO_W'(1);
    assign tmo_hit = (state == ST_ARMED) && (cfg_timeout != '0)
                   && to_zero && !wr;

    // Holdoff of N cycles: load N-1 so the exit fires in the Nth
    // HOLD cycle; zero still spends one cycle in HOLD.
    assign ho_ld  = (state == ST_DONE) && rd_done;
    assign ho_val = (cfg_holdoff == '0) ? '0
                  : cfg_holdoff - HO_W'(1);

    chip_dncnt #(.W(TO_W)) u_to (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .load     (to_ld),
        .load_val (to_val),
        .en       (state == ST_ARMED),
        .zero     (to_zero)
    );

    chip_dncnt #(.W(HO_W)) u_ho (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .load     (ho_ld),
        .load_val (ho_val),
        .en       (state == ST_HOLD),
        .zero     (ho_zero)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cfg_len_q <= LEN_W'(DEF_LEN);
            frm_path  <= '0;
            frm_cnt   <= '0;
            frm_done  <= 1'b0;
            irq       <= 1'b0;
            tmo       <= 1'b0;
            ovf       <= 1'b0;
            frm_num   <= '0;
        end else begin
            irq <= 1'b0;
            if (cmd_abort) begin
                state    <= ST_IDLE;
                frm_done <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (cmd_arm) begin
                            cfg_len_q <= eff_len(cfg_frame_len);
                            frm_cnt   <= '0;
                            frm_path  <= '0;
                            tmo       <= 1'b0;
                            ovf       <= 1'b0;
                            state     <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (wr) begin
                            frm_path <= ps.sel_path;
                            frm_cnt  <= cnt_nxt;
                            if (last) begin
                                frm_done <= 1'b1;
                                irq      <= 1'b1;
                                frm_num  <= frm_num + 16'd1;
                                state    <= ST_DONE;
                            end else begin
                                state <= ST_CAPT;
                            end
                        end else if (tmo_hit) begin
                            tmo   <= 1'b1;
                            irq   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_CAPT: begin
                        if (ps.d1_vld && !rdy) begin
                            ovf <= 1'b1;
                        end
                        if (wr) begin
                            frm_cnt <= cnt_nxt;
                            if (last) begin
                                frm_done <= 1'b1;
                                irq      <= 1'b1;
                                frm_num  <= frm_num + 16'd1;
                                state    <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (rd_done) begin
                            frm_done <= 1'b0;
                            state    <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (ho_zero) begin
                            if (cfg_cont) begin
                                frm_cnt <= '0;
                                state   <= ST_ARMED;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chip_cap_ctrl.sv
// Scoreboard bench for chip_cap_ctrl: directed captures,
// irq events checked by a monitor against queued expectations.
module tb_chip_cap_ctrl;

    typedef struct {
        logic [2:0]  st;
        logic        done;
        logic        tmo;
        logic        ovf;
        logic [15:0] num;
        logic [6:0]  path;
        logic [19:0] cnt;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        cmd_arm;
    logic        cmd_abort;
    logic        cfg_cont;
    logic [19:0] cfg_frame_len;
    logic [15:0] cfg_holdoff;
    logic [23:0] cfg_timeout;
    logic        rd_done;
    logic [6:0]  frm_path;
    logic [19:0] frm_cnt;
    logic        frm_done;
    logic        irq;
    logic        tmo;
    logic        ovf;
    logic [15:0] frm_num;
    logic [2:0]  st;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   wr_cnt = 0;
    int   irq_cnt = 0;
    int   wr0;
    int   irq0;

    chip_cap_ctrl_if ifc ();

    chip_cap_ctrl dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .cmd_arm       (cmd_arm),
        .cmd_abort     (cmd_abort),
        .cfg_cont      (cfg_cont),
        .cfg_frame_len (cfg_frame_len),
        .cfg_holdoff   (cfg_holdoff),
        .cfg_timeout   (cfg_timeout),
        .rd_done       (rd_done),
        .ps            (ifc),
        .frm_path      (frm_path),
        .frm_cnt       (frm_cnt),
        .frm_done      (frm_done),
        .irq           (irq),
        .tmo           (tmo),
        .ovf           (ovf),
        .frm_num       (frm_num),
        .st            (st)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic arm();
        cmd_arm = 1'b1;
        tick();
        cmd_arm = 1'b0;
    endtask

    task automatic push(
        input logic [2:0] s, input logic d, input logic t,
        input logic o, input logic [15:0] n,
        input logic [6:0] p, input logic [19:0] c
    );
        exp_t e;
        e.st = s; e.done = d; e.tmo = t; e.ovf = o;
        e.num = n; e.path = p; e.cnt = c;
        q.push_back(e);
    endtask

    // Monitor: counts writes and checks every irq against the queue.
    always @(negedge clk_sys) begin
        exp_t e;
        if (ifc.buf_wr) wr_cnt++;
        if (irq) begin
            irq_cnt++;
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL irq_unexp: got irq st=%0d want none", st);
            end else begin
                e = q.pop_front();
                chk("irq_st", 32'(st), 32'(e.st));
                chk("irq_done", 32'(frm_done), 32'(e.done));
                chk("irq_tmo", 32'(tmo), 32'(e.tmo));
                chk("irq_ovf", 32'(ovf), 32'(e.ovf));
                chk("irq_num", 32'(frm_num), 32'(e.num));
                chk("irq_path", 32'(frm_path), 32'(e.path));
                chk("irq_cnt", 32'(frm_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1;
        cmd_arm = 0; cmd_abort = 0; cfg_cont = 0;
        cfg_frame_len = 0; cfg_holdoff = 0; cfg_timeout = 0;
        rd_done = 0;
        ifc.d1_vld = 0; ifc.sel_path = 0; ifc.buf_afull = 0;
        #3;
        chk("rst_st", 32'(st), 0);
        chk("rst_len", 32'(ifc.cfg_len), 4000);
        chk("rst_num", 32'(frm_num), 0);
        chk("rst_rdy", 32'(ifc.buf_rdy), 0);
        chk("rst_irq", 32'(irq), 0);
        @(negedge clk_sys);
        rst = 1'b0;
        tick();

        // 1: default length frame
        wr0 = wr_cnt;
        arm();
        chk("t1_len", 32'(ifc.cfg_len), 4000);
        chk("t1_st", 32'(st), 1);
        push(3, 1, 0, 0, 1, 9, 4000);
        ifc.d1_vld = 1; ifc.sel_path = 9;
        repeat (4000) tick();
        ifc.d1_vld = 0;
        tick(); tick();
        chk("t1_wr", 32'(wr_cnt - wr0), 4000);
        chk("t1_st_done", 32'(st), 3);
        chk("t1_irqs", 32'(irq_cnt), 1);
        rd_done = 1; tick(); rd_done = 0;
        tick();
        chk("t1_idle", 32'(st), 0);

        // 2: len 8 with backpressure mid-frame
        cfg_frame_len = 8;
        wr0 = wr_cnt;
        arm();
        push(3, 1, 0, 1, 2, 3, 8);
        ifc.d1_vld = 1; ifc.sel_path = 3;
        tick();
        ifc.sel_path = 5;
        repeat (2) tick();
        ifc.buf_afull = 1;
        repeat (3) tick();
        ifc.buf_afull = 0;
        repeat (5) tick();
        ifc.d1_vld = 0;
        tick();
        chk("t2_wr", 32'(wr_cnt - wr0), 8);
        chk("t2_ovf", 32'(ovf), 1);
        rd_done = 1; tick(); rd_done = 0;
        tick();

        // 3: arm timeout of 100 cycles
        cfg_timeout = 100;
        push(0, 0, 1, 0, 2, 0, 0);
        arm();
        repeat (99) tick();
        chk("t3_armed", 32'(st), 1);
        tick();
        chk("t3_idle", 32'(st), 0);
        chk("t3_tmo", 32'(tmo), 1);
        chk("t3_rdy", 32'(ifc.buf_rdy), 0);
        cfg_timeout = 0;
        tick();

        // 4: continuous mode with holdoff 5
        cfg_frame_len = 4; cfg_cont = 1; cfg_holdoff = 5;
        arm();
        push(3, 1, 0, 0, 3, 2, 4);
        ifc.d1_vld = 1; ifc.sel_path = 2;
        repeat (4) tick();
        ifc.d1_vld = 0;
        tick();
        rd_done = 1; tick(); rd_done = 0;
        chk("t4_hold", 32'(st), 4);
        for (int i = 0; i < 5; i++) begin
            chk("t4_ho_rdy", 32'(ifc.buf_rdy), 0);
            tick();
        end
        chk("t4_rearm", 32'(st), 1);
        chk("t4_cnt0", 32'(frm_cnt), 0);
        push(3, 1, 0, 0, 4, 7, 4);
        ifc.d1_vld = 1; ifc.sel_path = 7;
        repeat (4) tick();
        ifc.d1_vld = 0;
        cfg_cont = 0; cfg_holdoff = 0;
        tick();
        rd_done = 1; tick(); rd_done = 0;
        tick();
        chk("t4_idle", 32'(st), 0);

        // 5: abort on the final write
        irq0 = irq_cnt;
        arm();
        ifc.d1_vld = 1;
        repeat (3) tick();
        cmd_abort = 1;
        tick();
        cmd_abort = 0; ifc.d1_vld = 0;
        chk("t5_st", 32'(st), 0);
        chk("t5_done", 32'(frm_done), 0);
        chk("t5_num", 32'(frm_num), 4);
        tick(); tick();
        chk("t5_noirq", 32'(irq_cnt), 32'(irq0));

        // 6: asynchronous reset mid-capture
        arm();
        ifc.d1_vld = 1;
        repeat (2) tick();
        ifc.d1_vld = 0;
        chk("t6_capt", 32'(st), 2);
        chk("t6_cnt2", 32'(frm_cnt), 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_st", 32'(st), 0);
        chk("t6_rst_cnt", 32'(frm_cnt), 0);
        chk("t6_rst_len", 32'(ifc.cfg_len), 4000);
        chk("t6_rst_num", 32'(frm_num), 0);
        chk("t6_rst_rdy", 32'(ifc.buf_rdy), 0);
        @(negedge clk_sys);
        rst = 1'b0;
        tick();
        arm();
        chk("t6_len", 32'(ifc.cfg_len), 4);
        push(3, 1, 0, 0, 1, 6, 4);
        ifc.d1_vld = 1; ifc.sel_path = 6;
        repeat (4) tick();
        ifc.d1_vld = 0;
        repeat (3) tick();

        chk("sb_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
